// File: rtl/railfence_decryption.sv
// Rail-fence (zigzag) decryption engine: buffers ciphertext until the start token arrives,
// then streams the plaintext out one character per cycle while busy is held high.
module railfence_decryption #(
  parameter int unsigned        D_WIDTH                = 8,
  parameter int unsigned        KEY_WIDTH              = 16,
  parameter int unsigned        MAX_KEY                = 8,
  parameter int unsigned        MAX_LEN                = 64,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(8'hFA)
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);
  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned PW = $clog2(2 * MAX_KEY);
  localparam int unsigned RW = $clog2(MAX_KEY);

  typedef enum logic [1:0] {StIdle, StFill, StPrefix, StDrain} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      wr_ptr_q, wr_ptr_d, n_q, n_d, p_q, p_d;
  logic [PW-1:0]      phase_q, phase_d, k_q, k_d, cyc_q, cyc_d;
  logic [CW-1:0]      cnt_q   [MAX_KEY];
  logic [CW-1:0]      cnt_d   [MAX_KEY];
  logic [CW-1:0]      start_q [MAX_KEY];
  logic [CW-1:0]      start_d [MAX_KEY];
  logic [CW-1:0]      rp_q    [MAX_KEY];
  logic [CW-1:0]      rp_d    [MAX_KEY];
  logic               busy_q, busy_d, valid_o_q, valid_o_d;
  logic [D_WIDTH-1:0] data_o_q, data_o_d;
  logic [D_WIDTH-1:0] buf_q   [MAX_LEN];
  logic               buf_we, clear;
  logic [PW-1:0]      key_eff, cyc_eff, k_use, cyc_use;
  logic [RW-1:0]      rail;
  logic [CW-1:0]      rd_addr, acc;

  // Phase walks 0..C-1; the descending half of the zigzag folds back onto rails K-2..1.
  function automatic logic [RW-1:0] rail_of(input logic [PW-1:0] ph, input logic [PW-1:0] k,
                                            input logic [PW-1:0] cyc);
    logic [PW-1:0] r;
    r = (ph < k) ? ph : cyc - ph;
    return r[RW-1:0];
  endfunction

  function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] ph,
                                               input logic [PW-1:0] cyc);
    return (ph + PW'(1) >= cyc) ? '0 : ph + PW'(1);
  endfunction

  always_comb begin
    if (key <= KEY_WIDTH'(1)) begin
      key_eff = PW'(1);
    end else if (key > KEY_WIDTH'(MAX_KEY)) begin
      key_eff = PW'(MAX_KEY);
    end else begin
      key_eff = key[PW-1:0];
    end
    cyc_eff = (key_eff == PW'(1)) ? PW'(1) : (key_eff << 1) - PW'(2);
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    n_d       = n_q;
    p_d       = p_q;
    phase_d   = phase_q;
    k_d       = k_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    rp_d      = rp_q;
    valid_o_d = 1'b0;
    data_o_d  = '0;
    buf_we    = 1'b0;
    clear     = 1'b0;
    k_use     = k_q;
    cyc_use   = cyc_q;
    rail      = '0;
    rd_addr   = '0;
    acc       = '0;

    unique case (state_q)
      StIdle, StFill: begin
        if (valid_i && !busy_q) begin
          if (data_i == START_DECRYPTION_TOKEN) begin
            n_d     = wr_ptr_q;
            state_d = StPrefix;
          end else if (wr_ptr_q != CW'(MAX_LEN)) begin
            // The key is captured with the first stored character and held for the message.
            if (wr_ptr_q == '0) begin
              k_use   = key_eff;
              cyc_use = cyc_eff;
              k_d     = key_eff;
              cyc_d   = cyc_eff;
            end
            rail        = rail_of(phase_q, k_use, cyc_use);
            cnt_d[rail] = cnt_q[rail] + CW'(1);
            phase_d     = next_phase(phase_q, cyc_use);
            wr_ptr_d    = wr_ptr_q + CW'(1);
            buf_we      = 1'b1;
            state_d     = StFill;
          end
        end
      end

      StPrefix: begin
        for (int r = 0; r < MAX_KEY; r++) begin
          start_d[r] = acc;
          acc        = acc + cnt_q[r];
          rp_d[r]    = '0;
        end
        phase_d = '0;
        p_d     = '0;
        if (n_q == '0) begin
          clear   = 1'b1;
          state_d = StIdle;
        end else begin
          // Plaintext index 0 is always rail 0 at offset 0, so it is emitted here directly.
          data_o_d  = buf_q[0];
          valid_o_d = 1'b1;
          rp_d[0]   = CW'(1);
          phase_d   = next_phase(PW'(0), cyc_q);
          p_d       = CW'(1);
          if (n_q == CW'(1)) begin
            clear   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        rail        = rail_of(phase_q, k_q, cyc_q);
        rd_addr     = start_q[rail] + rp_q[rail];
        data_o_d    = buf_q[rd_addr[AW-1:0]];
        valid_o_d   = 1'b1;
        rp_d[rail]  = rp_q[rail] + CW'(1);
        phase_d     = next_phase(phase_q, cyc_q);
        p_d         = p_q + CW'(1);
        if (p_q == n_q - CW'(1)) begin
          clear   = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (clear) begin
      wr_ptr_d = '0;
      phase_d  = '0;
      p_d      = '0;
      for (int r = 0; r < MAX_KEY; r++) begin
        cnt_d[r] = '0;
        rp_d[r]  = '0;
      end
    end

    // Busy covers PREFIX, DRAIN and the cycle carrying the last plaintext character.
    busy_d = (state_d == StPrefix) || (state_d == StDrain) || valid_o_d;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      n_q       <= '0;
      p_q       <= '0;
      phase_q   <= '0;
      k_q       <= PW'(1);
      cyc_q     <= PW'(1);
      busy_q    <= 1'b0;
      valid_o_q <= 1'b0;
      data_o_q  <= '0;
      for (int r = 0; r < MAX_KEY; r++) begin
        cnt_q[r]   <= '0;
        start_q[r] <= '0;
        rp_q[r]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      n_q       <= n_d;
      p_q       <= p_d;
      phase_q   <= phase_d;
      k_q       <= k_d;
      cyc_q     <= cyc_d;
      busy_q    <= busy_d;
      valid_o_q <= valid_o_d;
      data_o_q  <= data_o_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      rp_q      <= rp_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (buf_we) begin
      buf_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign busy    = busy_q;
  assign valid_o = valid_o_q;
  assign data_o  = data_o_q;

endmodule

// File: tb/tb_railfence_decryption.sv
// Bench for railfence_decryption: three instances (default, MAX_KEY=4, MAX_LEN=4) compared every
// cycle against a textbook rail-fence model, with literal plaintexts pinning the model.
`timescale 1ns/1ps
module tb_railfence_decryption;
  localparam int NDUT = 3;
  localparam int MAXC = 2048;
  localparam logic [7:0] TOK = 8'hFA;
  typedef logic [7:0] ch_t;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic [7:0]  din  [NDUT];
  logic        vin  [NDUT];
  logic [15:0] kin  [NDUT];
  logic        bsy  [NDUT];
  logic        vout [NDUT];
  logic [7:0]  dout [NDUT];

  railfence_decryption u_dut0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .data_i(din[0]), .valid_i(vin[0]), .key(kin[0]),
    .busy(bsy[0]), .data_o(dout[0]), .valid_o(vout[0])
  );
  railfence_decryption #(.MAX_KEY(4)) u_dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .data_i(din[1]), .valid_i(vin[1]), .key(kin[1]),
    .busy(bsy[1]), .data_o(dout[1]), .valid_o(vout[1])
  );
  railfence_decryption #(.MAX_LEN(4)) u_dut2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .data_i(din[2]), .valid_i(vin[2]), .key(kin[2]),
    .busy(bsy[2]), .data_o(dout[2]), .valid_o(vout[2])
  );

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_on = 1'b0;
  logic exp_b [NDUT][MAXC];
  logic exp_v [NDUT][MAXC];
  ch_t  exp_d [NDUT][MAXC];
  int   last_busy [NDUT];
  ch_t  got [NDUT][$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic int max_key(input int d);
    return (d == 1) ? 4 : 8;
  endfunction

  function automatic int max_len(input int d);
    return (d == 2) ? 4 : 64;
  endfunction

  function automatic int clamp_key(input int k, input int mk);
    if (k <= 1) return 1;
    if (k > mk) return mk;
    return k;
  endfunction

  // Classic rail-fence decryption: walk the zigzag, size each rail, slice and re-read.
  function automatic void rf_decrypt(input ch_t c[$], input int k, output ch_t p[$]);
    int rail[$];
    int len[$];
    int off[$];
    int used[$];
    int r, dir, rr;
    p = {};
    for (int i = 0; i < k; i++) begin
      len.push_back(0);
      used.push_back(0);
    end
    r = 0;
    dir = 1;
    for (int i = 0; i < c.size(); i++) begin
      rail.push_back(r);
      len[r] = len[r] + 1;
      if (k > 1) begin
        if (r == k - 1) dir = -1;
        else if (r == 0) dir = 1;
        r = r + dir;
      end
    end
    off.push_back(0);
    for (int i = 1; i < k; i++) off.push_back(off[i-1] + len[i-1]);
    for (int i = 0; i < c.size(); i++) begin
      rr = rail[i];
      p.push_back(c[off[rr] + used[rr]]);
      used[rr] = used[rr] + 1;
    end
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic check_text(input string name, input ch_t q[$], input string lit);
    int bad;
    bad = -1;
    checks++;
    if (q.size() == lit.len()) begin
      for (int i = 0; i < q.size(); i++) begin
        if (bad < 0 && q[i] != ch_t'(lit[i])) bad = i;
      end
    end
    if (q.size() != lit.len() || bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d chars (first diff at %0d), expected %0d chars \"%s\"",
               name, q.size(), bad, lit.len(), lit);
    end
  endtask

  always @(negedge clk_sys) begin
    if (cmp_on && cyc < MAXC) begin
      for (int d = 0; d < NDUT; d++) begin
        check($sformatf("dut%0d busy", d), bsy[d], exp_b[d][cyc]);
        check($sformatf("dut%0d valid_o", d), vout[d], exp_v[d][cyc]);
        check($sformatf("dut%0d data_o", d), dout[d], exp_d[d][cyc]);
        if (vout[d]) got[d].push_back(dout[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input ch_t ch, input logic [15:0] k);
    vin[d] = v;
    din[d] = ch;
    kin[d] = k;
  endtask

  task automatic wait_idle(input int d);
    while (cyc <= last_busy[d]) tick();
  endtask

  // Sends one message plus token; kf is the key on the first character, kr afterwards.
  task automatic send_msg(input int d, input string s, input int kf, input int kr,
                          output ch_t plain[$]);
    ch_t stored[$];
    int  k, t, kk;
    wait_idle(d);
    stored = {};
    k = 1;
    for (int i = 0; i < s.len(); i++) begin
      kk = (i == 0) ? kf : kr;
      drive(d, 1'b1, ch_t'(s[i]), 16'(kk));
      if (stored.size() < max_len(d)) begin
        if (stored.size() == 0) k = clamp_key(kk, max_key(d));
        stored.push_back(ch_t'(s[i]));
      end
      tick();
    end
    drive(d, 1'b1, TOK, 16'(kr));
    t = cyc;
    rf_decrypt(stored, k, plain);
    for (int c = t + 1; c <= t + plain.size() + 1; c++) exp_b[d][c] = 1'b1;
    for (int i = 0; i < plain.size(); i++) begin
      exp_v[d][t+2+i] = 1'b1;
      exp_d[d][t+2+i] = plain[i];
    end
    last_busy[d] = t + plain.size() + 1;
    tick();
    drive(d, 1'b0, 8'h00, 16'(kr));
  endtask

  task automatic finish_msg(input int d, input string name, input string lit);
    wait_idle(d);
    check_text({name, " stream"}, got[d], lit);
    got[d].delete();
  endtask

  task automatic run(input int d, input string name, input string s, input int kf,
                     input int kr, input string lit);
    ch_t plain[$];
    send_msg(d, s, kf, kr, plain);
    check_text({name, " model"}, plain, lit);
    finish_msg(d, name, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    ch_t plain[$];
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < MAXC; c++) begin
        exp_b[d][c] = 1'b0;
        exp_v[d][c] = 1'b0;
        exp_d[d][c] = 8'h00;
      end
      drive(d, 1'b0, 8'h00, 16'd0);
      last_busy[d] = 0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset dut%0d busy", d), bsy[d], 0);
      check($sformatf("reset dut%0d valid_o", d), vout[d], 0);
      check($sformatf("reset dut%0d data_o", d), dout[d], 0);
    end
    cmp_on = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) rst_n = 1'b1;
    tick();

    run(0, "key3", "WECRLTEERDSOEEFEAOCAIVDEN", 3, 3, "WEAREDISCOVEREDFLEEATONCE");
    run(0, "key2", "HLOEL", 2, 2, "HELLO");
    run(0, "key1", "ABC", 1, 1, "ABC");
    run(0, "key0", "XY", 0, 0, "XY");
    run(0, "empty", "", 3, 3, "");
    run(1, "clamp9", "ABFCED", 9, 9, "ABCDEF");
    run(1, "keychange", "ABFCED", 4, 2, "ABCDEF");
    run(1, "key3_small", "AEBDFC", 3, 3, "ABCDEF");
    run(2, "overflow", "ACBDZZ", 2, 2, "ABCD");

    // Characters (including a token) offered during drain must be ignored.
    send_msg(0, "HLOEL", 2, 2, plain);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, (i == 2) ? TOK : 8'h51, 16'd5);
      tick();
    end
    drive(0, 1'b0, 8'h00, 16'd2);
    finish_msg(0, "ignored", "HELLO");
    run(0, "after_ignore", "AEBDFC", 3, 3, "ABCDEF");

    // Asynchronous reset in the middle of a drain.
    send_msg(0, "WECRLTEERDSOEEFEAOCAIVDEN", 3, 3, plain);
    repeat (5) tick();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = cyc; c < MAXC; c++) begin
        exp_b[d][c] = 1'b0;
        exp_v[d][c] = 1'b0;
        exp_d[d][c] = 8'h00;
      end
      last_busy[d] = cyc;
    end
    rst_n = 1'b0;
    #1;
    check("midreset busy", bsy[0], 0);
    check("midreset valid_o", vout[0], 0);
    check("midreset data_o", dout[0], 0);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) rst_n = 1'b1;
    tick();
    got[0].delete();
    run(0, "post_reset", "HLOEL", 2, 2, "HELLO");

    repeat (3) tick();
    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
